// File: rtl/ddr_port_arbiter.sv
// Shares one Avalon-style DDR port among NumRequesters masters: round-robin grant with a
// bounded burst, plus a read-ID FIFO that steers in-order read data back to its issuer.
// Build option: define DDR_ARB_FIXED_PRIO_EN for lowest-index-first priority.
module ddr_port_arbiter #(
  parameter int NumRequesters  = 2,
  parameter int MaxOutstanding = 8,
  parameter int MaxGrantBeats  = 4,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NumRequesters-1:0][AddrWidth-1:0] req_address_i,
  input  logic [NumRequesters-1:0]                req_w_en_i,
  input  logic [NumRequesters-1:0][DataWidth-1:0] req_w_data_i,
  input  logic [NumRequesters-1:0]                req_r_en_i,
  output logic [NumRequesters-1:0]                req_waitrequest_n_o,
  output logic [NumRequesters-1:0][DataWidth-1:0] req_r_data_o,
  output logic [NumRequesters-1:0]                req_r_valid_o,
  output logic [AddrWidth-1:0]                    ddr_address_o,
  output logic                                    ddr_w_en_o,
  output logic [DataWidth-1:0]                    ddr_w_data_o,
  output logic                                    ddr_r_en_o,
  input  logic                                    ddr_waitrequest_n_i,
  input  logic [DataWidth-1:0]                    ddr_r_data_i,
  input  logic                                    ddr_r_valid_i,
  output logic                                    idle_o,
  output logic                                    err_o
);

  localparam int OwnerW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
  localparam int PtrW   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW   = PtrW + 1;
  localparam int BeatW  = $clog2(MaxGrantBeats + 1);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e            r_state;
  logic [OwnerW-1:0] r_owner;
  logic [OwnerW-1:0] r_rr_ptr;
  logic [BeatW-1:0]  r_beat_cnt;
  logic [OwnerW-1:0] r_fifo_mem [MaxOutstanding];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic              r_err;

  logic [NumRequesters-1:0] w_pending;
  logic                     w_any_pending;
  logic [OwnerW-1:0]        w_winner;
  logic [OwnerW-1:0]        w_next_ptr;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic                     w_own_w;
  logic                     w_own_r;
  logic                     w_own_cmd;
  logic                     w_own_read;
  logic                     w_accept;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_other_pending;
  logic                     w_conflict;
  logic                     w_resp_orphan;
  logic                     w_yield;
  logic [BeatW-1:0]         w_beat_next;

  // First pending index at or after start, wrapping around the requester list.
  function automatic logic [OwnerW-1:0] pick_winner(input logic [NumRequesters-1:0] pend,
                                                    input logic [OwnerW-1:0] start);
    logic [OwnerW-1:0] win;
    int                idx;
    win = '0;
    for (int i = NumRequesters - 1; i >= 0; i--) begin
      idx = (int'(start) + i) % NumRequesters;
      if (pend[idx]) begin
        win = OwnerW'(idx);
      end
    end
    return win;
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(MaxOutstanding - 1)) begin
      return '0;
    end else begin
      return ptr + PtrW'(1);
    end
  endfunction

  assign w_pending     = req_r_en_i | req_w_en_i;
  assign w_any_pending = |w_pending;
  assign w_fifo_full   = (r_count == CntW'(MaxOutstanding));
  assign w_fifo_empty  = (r_count == '0);
  assign w_next_ptr    = (r_owner == OwnerW'(NumRequesters - 1)) ? '0 : r_owner + OwnerW'(1);

`ifdef DDR_ARB_FIXED_PRIO_EN
  assign w_winner = pick_winner(w_pending, '0);
`else
  assign w_winner = pick_winner(w_pending, r_rr_ptr);
`endif

  // Competing demand that justifies ending the owner's burst.
  always_comb begin
    w_other_pending = 1'b0;
    for (int i = 0; i < NumRequesters; i++) begin
`ifdef DDR_ARB_FIXED_PRIO_EN
      if (w_pending[i] && (i < int'(r_owner))) begin
`else
      if (w_pending[i] && (OwnerW'(i) != r_owner)) begin
`endif
        w_other_pending = 1'b1;
      end else begin
        w_other_pending = w_other_pending;
      end
    end
  end

  // Owner command forwarding and accept handshake; a read with the write also set is dropped.
  always_comb begin
    w_own_w             = req_w_en_i[r_owner];
    w_own_r             = req_r_en_i[r_owner];
    w_own_cmd           = w_own_w | w_own_r;
    w_own_read          = w_own_r & ~w_own_w;
    w_accept            = 1'b0;
    ddr_address_o       = '0;
    ddr_w_data_o        = '0;
    ddr_w_en_o          = 1'b0;
    ddr_r_en_o          = 1'b0;
    req_waitrequest_n_o = '0;
    if (r_state == ST_GRANT) begin
      w_accept                     = w_own_cmd && ddr_waitrequest_n_i && !(w_own_read && w_fifo_full);
      ddr_address_o                = req_address_i[r_owner];
      ddr_w_data_o                 = req_w_data_i[r_owner];
      ddr_w_en_o                   = w_own_w;
      ddr_r_en_o                   = w_own_read & ~w_fifo_full;
      req_waitrequest_n_o[r_owner] = w_accept;
    end else begin
      w_accept = 1'b0;
    end
  end

  assign w_push        = w_accept & w_own_read;
  assign w_pop         = ddr_r_valid_i & ~w_fifo_empty;
  assign w_resp_orphan = ddr_r_valid_i & w_fifo_empty;
  assign w_conflict    = (r_state == ST_GRANT) & w_own_w & w_own_r;
  assign w_beat_next   = (r_beat_cnt >= BeatW'(MaxGrantBeats)) ? r_beat_cnt : r_beat_cnt + BeatW'(1);
  assign w_yield       = w_accept && (w_beat_next == BeatW'(MaxGrantBeats)) && w_other_pending;

  // Read return: data is broadcast, valid is steered to the ID at the FIFO head.
  always_comb begin
    req_r_valid_o = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      req_r_data_o[i] = ddr_r_data_i;
    end
    if (w_pop) begin
      req_r_valid_o[r_fifo_mem[r_rd_ptr]] = 1'b1;
    end else begin
      req_r_valid_o = '0;
    end
  end

  // Arbitration FSM: owner, round-robin pointer and burst counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= ST_ARB;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_any_pending) begin
            r_owner    <= w_winner;
            r_beat_cnt <= '0;
            r_state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!w_own_cmd || w_yield) begin
            r_state  <= ST_ARB;
            r_rr_ptr <= w_next_ptr;
          end else if (w_accept) begin
            r_beat_cnt <= w_beat_next;
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  // Read-ID FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Read-ID FIFO storage.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= r_owner;
    end
  end

  // Sticky protocol error: orphan read data or simultaneous read+write from the owner.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_conflict || w_resp_orphan) begin
      r_err <= 1'b1;
    end
  end

  assign idle_o = (r_state == ST_ARB) && !w_any_pending && w_fifo_empty;
  assign err_o  = r_err;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Bench for ddr_port_arbiter: cycle vector table, directed corner sequences and a
// randomized run checked against a transaction-level scoreboard.
module tb_ddr_port_arbiter;
  localparam int N = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAXO = 8;
  localparam int MAXB = 4;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic [N-1:0][AW-1:0] req_address_i;
  logic [N-1:0] req_w_en_i;
  logic [N-1:0][DW-1:0] req_w_data_i;
  logic [N-1:0] req_r_en_i;
  logic [N-1:0] req_waitrequest_n_o;
  logic [N-1:0][DW-1:0] req_r_data_o;
  logic [N-1:0] req_r_valid_o;
  logic [AW-1:0] ddr_address_o;
  logic ddr_w_en_o;
  logic [DW-1:0] ddr_w_data_o;
  logic ddr_r_en_o;
  logic ddr_waitrequest_n_i;
  logic [DW-1:0] ddr_r_data_i;
  logic ddr_r_valid_i;
  logic idle_o;
  logic err_o;

  always #5 clk_i = ~clk_i;

  ddr_port_arbiter #(
    .NumRequesters(N), .MaxOutstanding(MAXO), .MaxGrantBeats(MAXB),
    .AddrWidth(AW), .DataWidth(DW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_address_i(req_address_i), .req_w_en_i(req_w_en_i), .req_w_data_i(req_w_data_i),
    .req_r_en_i(req_r_en_i), .req_waitrequest_n_o(req_waitrequest_n_o),
    .req_r_data_o(req_r_data_o), .req_r_valid_o(req_r_valid_o),
    .ddr_address_o(ddr_address_o), .ddr_w_en_o(ddr_w_en_o), .ddr_w_data_o(ddr_w_data_o),
    .ddr_r_en_o(ddr_r_en_o), .ddr_waitrequest_n_i(ddr_waitrequest_n_i),
    .ddr_r_data_i(ddr_r_data_i), .ddr_r_valid_i(ddr_r_valid_i),
    .idle_o(idle_o), .err_o(err_o)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  w;
    logic [1:0]  r;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        wr;
    logic        rv;
    logic        er;
    logic        ew;
    logic [31:0] ea;
    logic [1:0]  ewrn;
    logic [1:0]  erv;
    logic        eidle;
    logic        eerr;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Scoreboard state for the randomized run
  bit          h_pend [N];
  bit          h_wr   [N];
  logic [31:0] h_addr [N];
  logic [31:0] h_data [N];
  int          idq[$];
  int          streak;
  int          streak_owner;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [1:0] w, input logic [1:0] r,
                              input logic [31:0] a0, input logic [31:0] a1, input logic wr,
                              input logic rv, input logic er, input logic ew, input logic [31:0] ea,
                              input logic [1:0] ewrn, input logic [1:0] erv, input logic eidle,
                              input logic eerr);
    vec_t v;
    v.rst = rst; v.w = w; v.r = r; v.a0 = a0; v.a1 = a1; v.wr = wr; v.rv = rv;
    v.er = er; v.ew = ew; v.ea = ea; v.ewrn = ewrn; v.erv = erv; v.eidle = eidle; v.eerr = eerr;
    return v;
  endfunction

  task automatic quiet_inputs();
    req_w_en_i = '0; req_r_en_i = '0; req_address_i = '0; req_w_data_i = '0;
    ddr_waitrequest_n_i = 1'b1; ddr_r_valid_i = 1'b0; ddr_r_data_i = '0;
  endtask

  task automatic reset_dut();
    quiet_inputs();
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  task automatic do_read(input int k, input logic [31:0] a);
    bit got;
    got = 1'b0;
    req_r_en_i[k] = 1'b1;
    req_address_i[k] = a;
    for (int t = 0; t < 20 && !got; t++) begin
      #1;
      got = req_waitrequest_n_o[k];
      @(posedge clk_i); #1;
    end
    req_r_en_i[k] = 1'b0;
    chk(got, $sformatf("read%0d_accept", k), 64'(got), 64'd1);
  endtask

  task automatic rand_cycle(input bit allow_new);
    logic [1:0]  acc;
    logic [1:0]  exp_rv;
    logic [31:0] rdata;
    bit          rv;
    int          k;
    for (int i = 0; i < N; i++) begin
      if (!h_pend[i] && allow_new && ($urandom % 2 == 0)) begin
        h_pend[i] = 1'b1;
        h_wr[i]   = 1'($urandom % 2);
        h_addr[i] = $urandom;
        h_data[i] = $urandom;
      end
      req_w_en_i[i]    = h_pend[i] && h_wr[i];
      req_r_en_i[i]    = h_pend[i] && !h_wr[i];
      req_address_i[i] = h_addr[i];
      req_w_data_i[i]  = h_data[i];
    end
    ddr_waitrequest_n_i = allow_new ? ($urandom % 4 != 0) : 1'b1;
    rv = (idq.size() > 0) && (allow_new ? ($urandom % 3 == 0) : 1'b1);
    rdata = $urandom;
    ddr_r_valid_i = rv;
    ddr_r_data_i = rdata;
    #1;
    acc = req_waitrequest_n_o;
    chk(($countones(acc) <= 1) && ((acc != 2'b00) == ((ddr_r_en_o || ddr_w_en_o) && ddr_waitrequest_n_i)),
        "rnd_accept", 64'(acc), {61'd0, ddr_r_en_o, ddr_w_en_o, ddr_waitrequest_n_i});
    k = acc[1] ? 1 : 0;
    if (acc != 2'b00) begin
      chk(h_pend[k] && (ddr_address_o == h_addr[k]) && (ddr_w_en_o == h_wr[k]) &&
          (ddr_r_en_o == !h_wr[k]) && (!h_wr[k] || ddr_w_data_o == h_data[k]),
          "rnd_fwd", {ddr_address_o, ddr_w_data_o}, {h_addr[k], h_data[k]});
      if (h_pend[1-k]) begin
        if (streak_owner == k) streak++;
        else begin streak_owner = k; streak = 1; end
      end else begin
        streak_owner = k; streak = 0;
      end
      chk(streak <= MAXB, "rnd_burst", 64'(streak), 64'(MAXB));
    end
    if (rv) begin
      exp_rv = 2'b00;
      exp_rv[idq[0]] = 1'b1;
      chk((req_r_valid_o == exp_rv) && (req_r_data_o[idq[0]] == rdata), "rnd_resp",
          {30'd0, req_r_valid_o, req_r_data_o[idq[0]]}, {30'd0, exp_rv, rdata});
      void'(idq.pop_front());
    end else begin
      chk(req_r_valid_o == 2'b00, "rnd_noresp", 64'(req_r_valid_o), 64'd0);
    end
    if (acc != 2'b00) begin
      if (!h_wr[k]) idq.push_back(k);
      h_pend[k] = 1'b0;
    end
    chk(idq.size() <= MAXO, "rnd_outstanding", 64'(idq.size()), 64'(MAXO));
    chk(err_o == 1'b0, "rnd_err", 64'(err_o), 64'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [20];
    logic [1:0]  exp2 [15];
    logic [39:0] obs, expv;
    logic [31:0] ea;
    int          outst;
    int          acc_cnt;
    bit          blocked;
    bit          done;

    // Test 1 rows 0-7, reset row 8, test 3 rows 9-19
    vecs[0]  = mk(1, 2'b00, 2'b01, 32'h40, 32'h0, 1, 0, 0, 0, 32'h0,   2'b00, 2'b00, 0, 0);
    vecs[1]  = mk(1, 2'b00, 2'b01, 32'h40, 32'h0, 1, 0, 1, 0, 32'h40,  2'b01, 2'b00, 0, 0);
    vecs[2]  = mk(1, 2'b00, 2'b00, 32'h0,  32'h0, 1, 0, 0, 0, 32'h0,   2'b00, 2'b00, 0, 0);
    vecs[3]  = mk(1, 2'b00, 2'b00, 32'h0,  32'h0, 1, 0, 0, 0, 32'h0,   2'b00, 2'b00, 0, 0);
    vecs[4]  = mk(1, 2'b00, 2'b00, 32'h0,  32'h0, 1, 0, 0, 0, 32'h0,   2'b00, 2'b00, 0, 0);
    vecs[5]  = mk(1, 2'b00, 2'b00, 32'h0,  32'h0, 1, 0, 0, 0, 32'h0,   2'b00, 2'b00, 0, 0);
    vecs[6]  = mk(1, 2'b00, 2'b00, 32'h0,  32'h0, 1, 1, 0, 0, 32'h0,   2'b00, 2'b01, 0, 0);
    vecs[7]  = mk(1, 2'b00, 2'b00, 32'h0,  32'h0, 1, 0, 0, 0, 32'h0,   2'b00, 2'b00, 1, 0);
    vecs[8]  = mk(0, 2'b00, 2'b00, 32'h0,  32'h0, 1, 0, 0, 0, 32'h0,   2'b00, 2'b00, 1, 0);
    vecs[9]  = mk(1, 2'b01, 2'b10, 32'h100, 32'h200, 0, 0, 0, 0, 32'h0,   2'b00, 2'b00, 0, 0);
    vecs[10] = mk(1, 2'b01, 2'b10, 32'h100, 32'h200, 0, 0, 0, 1, 32'h100, 2'b00, 2'b00, 0, 0);
    vecs[11] = mk(1, 2'b01, 2'b10, 32'h100, 32'h200, 0, 0, 0, 1, 32'h100, 2'b00, 2'b00, 0, 0);
    vecs[12] = mk(1, 2'b01, 2'b10, 32'h100, 32'h200, 0, 0, 0, 1, 32'h100, 2'b00, 2'b00, 0, 0);
    vecs[13] = mk(1, 2'b01, 2'b10, 32'h100, 32'h200, 1, 0, 0, 1, 32'h100, 2'b01, 2'b00, 0, 0);
    vecs[14] = mk(1, 2'b00, 2'b10, 32'h0,   32'h200, 1, 0, 0, 0, 32'h0,   2'b00, 2'b00, 0, 0);
    vecs[15] = mk(1, 2'b00, 2'b10, 32'h0,   32'h200, 1, 0, 0, 0, 32'h0,   2'b00, 2'b00, 0, 0);
    vecs[16] = mk(1, 2'b00, 2'b10, 32'h0,   32'h200, 1, 0, 1, 0, 32'h200, 2'b10, 2'b00, 0, 0);
    vecs[17] = mk(1, 2'b00, 2'b00, 32'h0,   32'h0,   1, 0, 0, 0, 32'h0,   2'b00, 2'b00, 0, 0);
    vecs[18] = mk(1, 2'b00, 2'b00, 32'h0,   32'h0,   1, 1, 0, 0, 32'h0,   2'b00, 2'b10, 0, 0);
    vecs[19] = mk(1, 2'b00, 2'b00, 32'h0,   32'h0,   1, 0, 0, 0, 32'h0,   2'b00, 2'b00, 1, 0);

    exp2[0] = 2'b00; exp2[1] = 2'b01; exp2[2] = 2'b01; exp2[3] = 2'b01; exp2[4] = 2'b01;
    exp2[5] = 2'b00; exp2[6] = 2'b10; exp2[7] = 2'b10; exp2[8] = 2'b10; exp2[9] = 2'b10;
    exp2[10] = 2'b00; exp2[11] = 2'b01; exp2[12] = 2'b01; exp2[13] = 2'b01; exp2[14] = 2'b01;

    @(negedge clk_i);
    reset_dut();
    #1;
    obs = {ddr_r_en_o, ddr_w_en_o, ddr_address_o, req_waitrequest_n_o, req_r_valid_o, idle_o, err_o};
    chk(obs === 40'h00_0000_0002, "reset_state", 64'(obs), 64'h2);
    chk(ddr_w_data_o === 32'h0, "reset_wdata", 64'(ddr_w_data_o), 64'h0);
    @(posedge clk_i); #1;

    for (int i = 0; i < 20; i++) begin
      rst_ni = vecs[i].rst;
      req_w_en_i = vecs[i].w;
      req_r_en_i = vecs[i].r;
      req_address_i[0] = vecs[i].a0;
      req_address_i[1] = vecs[i].a1;
      req_w_data_i[0] = vecs[i].a0 ^ 32'hA5A5_0000;
      req_w_data_i[1] = vecs[i].a1 ^ 32'h5A5A_0000;
      ddr_waitrequest_n_i = vecs[i].wr;
      ddr_r_valid_i = vecs[i].rv;
      ddr_r_data_i = 32'hD0D0_0000 + 32'(i);
      #1;
      obs = {ddr_r_en_o, ddr_w_en_o, ddr_address_o, req_waitrequest_n_o, req_r_valid_o, idle_o, err_o};
      expv = {vecs[i].er, vecs[i].ew, vecs[i].ea, vecs[i].ewrn, vecs[i].erv, vecs[i].eidle, vecs[i].eerr};
      chk(obs === expv, $sformatf("vec%0d", i), 64'(obs), 64'(expv));
      chk((req_r_data_o[0] == ddr_r_data_i) && (req_r_data_o[1] == ddr_r_data_i),
          $sformatf("vec%0d_rdata", i), 64'(req_r_data_o), {ddr_r_data_i, ddr_r_data_i});
      @(posedge clk_i); #1;
    end
    rst_ni = 1'b1;

    // Round-robin with burst limit under continuous reads from both requesters
    reset_dut();
    req_address_i[0] = 32'h1000;
    req_address_i[1] = 32'h1004;
    req_r_en_i = 2'b11;
    outst = 0;
    for (int i = 0; i < 15; i++) begin
      ddr_r_valid_i = (outst > 0);
      #1;
      ea = exp2[i][1] ? 32'h1004 : 32'h1000;
      chk((req_waitrequest_n_o == exp2[i]) && (ddr_r_en_o == (exp2[i] != 2'b00)) &&
          ((exp2[i] == 2'b00) || (ddr_address_o == ea)), $sformatf("rr%0d", i),
          {29'd0, ddr_r_en_o, req_waitrequest_n_o, ddr_address_o}, {29'd0, (exp2[i] != 2'b00), exp2[i], ea});
      if (req_waitrequest_n_o != 2'b00) outst++;
      if (ddr_r_valid_i) outst--;
      @(posedge clk_i); #1;
    end
    req_r_en_i = 2'b00;
    ddr_r_valid_i = (outst > 0);
    @(posedge clk_i); #1;
    ddr_r_valid_i = 1'b0;

    // FIFO full blocks the ninth read until a response frees a slot
    reset_dut();
    req_address_i[0] = 32'h2000;
    req_r_en_i = 2'b01;
    acc_cnt = 0;
    blocked = 1'b0;
    for (int i = 0; i < 11; i++) begin
      #1;
      if (req_waitrequest_n_o[0]) acc_cnt++;
      blocked = !ddr_r_en_o && (req_waitrequest_n_o == 2'b00);
      @(posedge clk_i); #1;
    end
    chk(acc_cnt == MAXO, "full_accepts", 64'(acc_cnt), 64'(MAXO));
    chk(blocked, "full_blocked", 64'(blocked), 64'd1);
    ddr_r_valid_i = 1'b1;
    #1;
    chk((req_r_valid_o == 2'b01) && !ddr_r_en_o && (req_waitrequest_n_o == 2'b00), "full_pop",
        {59'd0, req_r_valid_o, ddr_r_en_o, req_waitrequest_n_o}, {59'd0, 2'b01, 1'b0, 2'b00});
    @(posedge clk_i); #1;
    ddr_r_valid_i = 1'b0;
    #1;
    chk(ddr_r_en_o && (req_waitrequest_n_o == 2'b01), "full_resume",
        {61'd0, ddr_r_en_o, req_waitrequest_n_o}, {61'd0, 1'b1, 2'b01});
    @(posedge clk_i); #1;
    req_r_en_i = 2'b00;
    ddr_r_valid_i = 1'b1;
    for (int i = 0; i < MAXO; i++) begin
      #1;
      chk(req_r_valid_o == 2'b01, $sformatf("full_drain%0d", i), 64'(req_r_valid_o), 64'd1);
      @(posedge clk_i); #1;
    end
    ddr_r_valid_i = 1'b0;
    #1;
    chk(idle_o == 1'b1, "full_idle", 64'(idle_o), 64'd1);
    @(posedge clk_i); #1;

    // In-order response routing across requesters
    reset_dut();
    do_read(0, 32'h3000);
    do_read(1, 32'h3004);
    do_read(0, 32'h3008);
    ddr_r_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      ea = (i == 1) ? 32'd2 : 32'd1;
      chk(req_r_valid_o == ea[1:0], $sformatf("route%0d", i), 64'(req_r_valid_o), 64'(ea));
      @(posedge clk_i); #1;
    end
    ddr_r_valid_i = 1'b0;
    #1;
    chk(idle_o == 1'b1, "route_idle", 64'(idle_o), 64'd1);
    @(posedge clk_i); #1;

    // Orphan response sets sticky error; reset clears it
    reset_dut();
    ddr_r_valid_i = 1'b1;
    #1;
    chk((req_r_valid_o == 2'b00) && (err_o == 1'b0), "orphan_novalid",
        {61'd0, req_r_valid_o, err_o}, 64'd0);
    @(posedge clk_i); #1;
    ddr_r_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk(err_o == 1'b1, $sformatf("orphan_sticky%0d", i), 64'(err_o), 64'd1);
      @(posedge clk_i); #1;
    end
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    #1;
    chk((err_o == 1'b0) && (idle_o == 1'b1), "orphan_reset", {62'd0, err_o, idle_o}, 64'd1);
    @(posedge clk_i); #1;

    // Conflicting read+write from the owner: write goes out, read suppressed, error set
    reset_dut();
    req_w_en_i = 2'b01;
    req_r_en_i = 2'b01;
    req_address_i[0] = 32'h4000;
    @(posedge clk_i); #1;
    #1;
    chk(ddr_w_en_o && !ddr_r_en_o && (req_waitrequest_n_o == 2'b01), "conflict_fwd",
        {61'd0, ddr_w_en_o, ddr_r_en_o, req_waitrequest_n_o[0]}, 64'h5);
    @(posedge clk_i); #1;
    quiet_inputs();
    #1;
    chk(err_o == 1'b1, "conflict_err", 64'(err_o), 64'd1);
    @(posedge clk_i); #1;

    // Randomized traffic against the transaction scoreboard
    reset_dut();
    for (int i = 0; i < N; i++) h_pend[i] = 1'b0;
    idq.delete();
    streak = 0;
    streak_owner = -1;
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      rand_cycle(1'b0);
      done = (idq.size() == 0) && !h_pend[0] && !h_pend[1];
    end
    chk(done, "drain_timeout", 64'(idq.size()), 64'd0);
    rand_cycle(1'b0);
    rand_cycle(1'b0);
    ddr_r_valid_i = 1'b0;
    #1;
    chk(idle_o == 1'b1, "rnd_idle", 64'(idle_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
